pin_controller: RTL and testbench
=================================

PIN_CONTROLLER -- requirements
Module: pin_controller

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, single clock domain.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-low reset.
REQ-003 SHALL have ports: cfg_en  in  1  register access strobe from command block.
REQ-004 SHALL have ports: cfg_wr  in  1  1=write, 0=read, qualified by cfg_en.
REQ-005 SHALL have ports: cfg_addr  in  3  register word offset.
REQ-006 SHALL have ports: cfg_wdata  in  16  write data.
REQ-007 SHALL have ports: cfg_rdata  out  16  read data, registered.
REQ-008 SHALL have ports: pin_out  out  1  driven digital pin.
REQ-009 SHALL have ports: sample  out  16  current waveform amplitude.
REQ-010 SHALL have ports: busy  out  1  high in ARMED or RUN.
REQ-011 SHALL have ports: done  out  1  one-cycle pulse on tick-count completion.

Function
REQ-012 SHALL map registers: 0 WAVE (1 square, 2 sawtooth, 3 triangle, 4 pwm); 1 PERIOD (clk cycles); 2 PHASE (delay cycles before first period); 3 TICKS (periods to run, 0 = forever); 4 DUTY (pwm high cycles); 5 CTRL (bit0: 1 start, 0 stop); 6 CUR_TICK (RO); 7 LAST_VAL (RO).
REQ-013 SHALL return cfg_rdata one cycle after a read strobe; CTRL reads {15'b0, busy}; writes to 6/7 ignored.
REQ-014 SHALL implement states IDLE, ARMED, RUN, DONE; IDLE->ARMED on CTRL start with WAVE in 1..4; start with any other WAVE ignored.
REQ-015 SHALL, in ARMED, count PHASE cycles then enter RUN with cnt=0; PHASE=0 enters RUN on the next cycle.
REQ-016 SHALL, in RUN, count cnt 0..P-1 and wrap, where P = max(PERIOD,2); each wrap increments CUR_TICK (16-bit, wraps 0xFFFF->0 when TICKS=0).
REQ-017 SHALL, when TICKS!=0 and CUR_TICK reaches TICKS at a wrap, enter DONE for one cycle (done=1), then IDLE.
REQ-018 SHALL produce square: pin_out = (cnt < P>>1), sample = pin_out ? 16'hFFFF : 0.
REQ-019 SHALL produce sawtooth: sample = cnt, pin_out = 0.
REQ-020 SHALL produce triangle: sample = 2*cnt for cnt < P>>1, else 2*(P-1-cnt), saturated to 16'hFFFF; pin_out = 0.
REQ-021 SHALL produce pwm: pin_out = (cnt < DUTY), DUTY >= P gives constant high, DUTY=0 constant low; sample = pin_out ? 16'hFFFF : 0.
REQ-022 SHALL shadow WAVE, PERIOD, DUTY into active copies at start and at each period wrap; mid-period writes take effect at the next wrap.
REQ-023 SHALL, on CTRL stop in ARMED or RUN, go IDLE next cycle without done pulse; start while busy restarts from ARMED with CUR_TICK=0.
REQ-024 SHALL latch LAST_VAL = sample on every exit from RUN (completion or stop).
REQ-025 SHALL hold pin_out=0, sample=0 in IDLE, ARMED, DONE; CUR_TICK cleared on start, held otherwise.

Reset
REQ-026 SHALL, on reset low at a clk edge, clear all registers, cnt, CUR_TICK, LAST_VAL, cfg_rdata to 0, state to IDLE, outputs to 0, aborting any run.

Structure
REQ-027 SHALL place waveform codes, register offsets and state encodings in shared package mecobo_pkg.
REQ-028 SHALL be one module; a waveform-shaping sub-module wave_shaper (cnt, P, DUTY, WAVE -> pin_out, sample) is permitted.

Verification
REQ-029 SHALL test square WAVE=1, PERIOD=10, PHASE=0, TICKS=3: pin_out high 5/low 5 ×3, done after 30 RUN cycles, CUR_TICK reads 3.
REQ-030 SHALL test pwm PERIOD=8, DUTY=3 then DUTY=6 mid-period: current period 3 high, next period 6 high.
REQ-031 SHALL test triangle PERIOD=6: sample sequence 0,2,4,4,2,0 repeating.
REQ-032 SHALL test PHASE=4, PERIOD=1: busy rises, 4 ARMED cycles, then period treated as 2.
REQ-033 SHALL test stop at cnt=3 of sawtooth PERIOD=16: no done, LAST_VAL reads 3, pin_out/sample 0.
REQ-034 SHALL test reset asserted mid-RUN: next cycle all outputs 0, state IDLE, all registers read 0.

Source files
------------

// File: rtl/mecobo_pkg.sv
// -----------------------------------------------------------------------------
// mecobo_pkg
// Shared definitions for the pin_controller waveform generator:
//   - waveform codes held in the WAVE register
//   - register word offsets on the cfg_* access port
//   - controller state encoding
//   - the shadowed (active) waveform configuration record
//   - small helpers for waveform validity and effective period
// -----------------------------------------------------------------------------
package mecobo_pkg;

    localparam logic [15:0] WAVE_SQUARE = 16'd1;
    localparam logic [15:0] WAVE_SAW    = 16'd2;
    localparam logic [15:0] WAVE_TRI    = 16'd3;
    localparam logic [15:0] WAVE_PWM    = 16'd4;

    typedef enum logic [2:0] {
        ADDR_WAVE     = 3'd0,
        ADDR_PERIOD   = 3'd1,
        ADDR_PHASE    = 3'd2,
        ADDR_TICKS    = 3'd3,
        ADDR_DUTY     = 3'd4,
        ADDR_CTRL     = 3'd5,
        ADDR_CUR_TICK = 3'd6,
        ADDR_LAST_VAL = 3'd7
    } reg_addr_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Configuration actually driving the waveform; refreshed only at start
    // and at period wraps so that mid-period writes never glitch a period.
    typedef struct packed {
        logic [15:0] wave;
        logic [15:0] period;
        logic [15:0] duty;
    } shadow_t;

    function automatic logic wave_valid(input logic [15:0] wave);
        return (wave >= WAVE_SQUARE) && (wave <= WAVE_PWM);
    endfunction

    // A period shorter than two cycles cannot hold both halves of a wave.
    function automatic logic [15:0] eff_period(input logic [15:0] period);
        return (period < 16'd2) ? 16'd2 : period;
    endfunction

endpackage

// File: rtl/wave_shaper.sv
// -----------------------------------------------------------------------------
// wave_shaper
// Pure combinational mapping from the position inside a period to the pin
// level and amplitude sample for the selected waveform.
// Ports:
//   cnt_i     [15:0] position in the current period, 0 .. period_i-1
//   period_i  [15:0] effective period (already at least 2)
//   duty_i    [15:0] pwm high cycles
//   wave_i    [15:0] waveform code (unknown codes give pin 0, sample 0)
//   pin_out_o        digital pin level
//   sample_o  [15:0] waveform amplitude
// -----------------------------------------------------------------------------
module wave_shaper
    import mecobo_pkg::*;
(
    input  logic [15:0] cnt_i,
    input  logic [15:0] period_i,
    input  logic [15:0] duty_i,
    input  logic [15:0] wave_i,
    output logic        pin_out_o,
    output logic [15:0] sample_o
);

    logic [15:0] half;
    logic [16:0] tri_raw;

    assign half = period_i >> 1;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path through the case leaves it unassigned and infers a latch.
        pin_out_o = 1'b0;
        sample_o  = 16'h0000;
        tri_raw   = 17'h0_0000;
        case (wave_i)
            WAVE_SQUARE: begin
                pin_out_o = (cnt_i < half);
                sample_o  = pin_out_o ? 16'hFFFF : 16'h0000;
            end
            WAVE_SAW: begin
                sample_o = cnt_i;
            end
            WAVE_TRI: begin
                // Doubling needs one extra bit before saturating.
                if (cnt_i < half) begin
                    tri_raw = {cnt_i, 1'b0};
                end else begin
                    tri_raw = {period_i - 16'd1 - cnt_i, 1'b0};
                end
                sample_o = tri_raw[16] ? 16'hFFFF : tri_raw[15:0];
            end
            WAVE_PWM: begin
                // DUTY >= period is naturally constant high, DUTY = 0 constant low.
                pin_out_o = (cnt_i < duty_i);
                sample_o  = pin_out_o ? 16'hFFFF : 16'h0000;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/pin_controller.sv
// -----------------------------------------------------------------------------
// pin_controller
// Register-programmed waveform generator driving one digital pin and a
// 16-bit amplitude sample. A run waits PHASE cycles (ARMED), then repeats
// periods (RUN) until TICKS periods have elapsed or it is stopped.
// Ports:
//   clk              system clock
//   reset            synchronous, active-low reset
//   cfg_en           register access strobe
//   cfg_wr           1 = write, 0 = read (qualified by cfg_en)
//   cfg_addr  [2:0]  register word offset
//   cfg_wdata [15:0] write data
//   cfg_rdata [15:0] read data, valid the cycle after a read strobe
//   pin_out          driven digital pin
//   sample    [15:0] current waveform amplitude
//   busy             high while ARMED or RUN
//   done             one-cycle pulse after the last counted period
// -----------------------------------------------------------------------------
module pin_controller
    import mecobo_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        cfg_en,
    input  logic        cfg_wr,
    input  logic [2:0]  cfg_addr,
    input  logic [15:0] cfg_wdata,
    output logic [15:0] cfg_rdata,
    output logic        pin_out,
    output logic [15:0] sample,
    output logic        busy,
    output logic        done
);

    // Programmable registers
    logic [15:0] wave_q, period_q, phase_q, ticks_q, duty_q;
    logic [15:0] rdata_q, rdata_d;

    // Run state
    state_e      state_q;
    shadow_t     act_q;
    logic [15:0] cnt_q;
    logic [15:0] phase_left_q;
    logic [15:0] cur_tick_q, cur_tick_d;
    logic [15:0] last_val_q;

    logic [15:0] p_eff;
    logic        shaper_pin;
    logic [15:0] shaper_sample;
    logic        wr_ctrl, start_req, stop_req, wrap, complete, in_run;

    assign in_run     = (state_q == ST_RUN);
    assign p_eff      = eff_period(act_q.period);
    assign wrap       = (cnt_q == p_eff - 16'd1);
    assign cur_tick_d = cur_tick_q + 16'd1;
    assign complete   = wrap && (ticks_q != 16'd0) && (cur_tick_d == ticks_q);

    assign wr_ctrl    = cfg_en && cfg_wr && (cfg_addr == ADDR_CTRL);
    assign start_req  = wr_ctrl && cfg_wdata[0] && wave_valid(wave_q);
    assign stop_req   = wr_ctrl && !cfg_wdata[0];

    wave_shaper u_shaper (
        .cnt_i     (cnt_q),
        .period_i  (p_eff),
        .duty_i    (act_q.duty),
        .wave_i    (act_q.wave),
        .pin_out_o (shaper_pin),
        .sample_o  (shaper_sample)
    );

    assign pin_out   = in_run && shaper_pin;
    assign sample    = in_run ? shaper_sample : 16'h0000;
    assign busy      = (state_q == ST_ARMED) || in_run;
    assign done      = (state_q == ST_DONE);
    assign cfg_rdata = rdata_q;

    always_comb begin
        rdata_d = 16'h0000;
        case (reg_addr_e'(cfg_addr))
            ADDR_WAVE:     rdata_d = wave_q;
            ADDR_PERIOD:   rdata_d = period_q;
            ADDR_PHASE:    rdata_d = phase_q;
            ADDR_TICKS:    rdata_d = ticks_q;
            ADDR_DUTY:     rdata_d = duty_q;
            ADDR_CTRL:     rdata_d = {15'd0, busy};
            ADDR_CUR_TICK: rdata_d = cur_tick_q;
            ADDR_LAST_VAL: rdata_d = last_val_q;
            default:       rdata_d = 16'h0000;
        endcase
    end

    // Register file and read port. CTRL is a pure command; offsets 6/7 are
    // read-only status, so writes to them fall through the default.
    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: reset is sampled only at the clock edge, so it lives inside
            // the clocked branch and is absent from the sensitivity list.
            wave_q   <= '0;
            period_q <= '0;
            phase_q  <= '0;
            ticks_q  <= '0;
            duty_q   <= '0;
            rdata_q  <= '0;
        end else begin
            if (cfg_en && cfg_wr) begin
                case (reg_addr_e'(cfg_addr))
                    ADDR_WAVE:   wave_q   <= cfg_wdata;
                    ADDR_PERIOD: period_q <= cfg_wdata;
                    ADDR_PHASE:  phase_q  <= cfg_wdata;
                    ADDR_TICKS:  ticks_q  <= cfg_wdata;
                    ADDR_DUTY:   duty_q   <= cfg_wdata;
                    default: ;
                endcase
            end
            if (cfg_en && !cfg_wr) begin
                rdata_q <= rdata_d;
            end
        end
    end

    // Controller FSM. Commands (start/stop) take priority over the run's own
    // progress, so a stop on the completing wrap produces no done pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            act_q        <= '0;
            cnt_q        <= '0;
            phase_left_q <= '0;
            cur_tick_q   <= '0;
            last_val_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments everywhere in clocked logic, so
            // every right-hand side sees the pre-edge value of the registers.
            if (in_run && (start_req || stop_req || complete)) begin
                last_val_q <= sample;
            end

            if (start_req) begin
                state_q      <= ST_ARMED;
                act_q        <= {wave_q, period_q, duty_q};
                cnt_q        <= '0;
                phase_left_q <= phase_q;
                cur_tick_q   <= '0;
            end else if (stop_req && busy) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_ARMED: begin
                        // PHASE of 0 or 1 both leave ARMED after one cycle.
                        if (phase_left_q <= 16'd1) begin
                            state_q <= ST_RUN;
                            cnt_q   <= '0;
                        end else begin
                            phase_left_q <= phase_left_q - 16'd1;
                        end
                    end
                    ST_RUN: begin
                        if (wrap) begin
                            cnt_q      <= '0;
                            cur_tick_q <= cur_tick_d;
                            act_q      <= {wave_q, period_q, duty_q};
                            if (complete) begin
                                state_q <= ST_DONE;
                            end
                        end else begin
                            cnt_q <= cnt_q + 16'd1;
                        end
                    end
                    ST_DONE: state_q <= ST_IDLE;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pin_controller.sv
// -----------------------------------------------------------------------------
// tb_pin_controller
// Self-checking bench for pin_controller. A behavioural model advanced on
// every rising edge predicts pin_out, sample, busy, done and cfg_rdata; a
// compare process checks them on every falling edge. Directed scenarios add
// hand-computed expectations, then randomized register traffic follows.
// -----------------------------------------------------------------------------
module tb_pin_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cfg_en = 1'b0;
    logic        cfg_wr = 1'b0;
    logic [2:0]  cfg_addr = 3'd0;
    logic [15:0] cfg_wdata = 16'h0000;
    logic [15:0] cfg_rdata;
    logic        pin_out;
    logic [15:0] sample;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    pin_controller dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_en    (cfg_en),
        .cfg_wr    (cfg_wr),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .pin_out   (pin_out),
        .sample    (sample),
        .busy      (busy),
        .done      (done)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int M_IDLE = 0, M_ARMED = 1, M_RUN = 2, M_DONE = 3;

    int m_reg[5];            // WAVE, PERIOD, PHASE, TICKS, DUTY
    int m_mode     = M_IDLE;
    int m_arm_left = 0;      // ARMED cycles still to spend
    int m_cnt      = 0;
    int m_tick     = 0;
    int m_last     = 0;
    int m_rdata    = 0;
    int a_wave     = 0, a_period = 0, a_duty = 0;

    function automatic int m_p();
        return (a_period < 2) ? 2 : a_period;
    endfunction

    function automatic int m_pin();
        if (m_mode != M_RUN) return 0;
        if (a_wave == 1) return (m_cnt < m_p() / 2) ? 1 : 0;
        if (a_wave == 4) return (m_cnt < a_duty) ? 1 : 0;
        return 0;
    endfunction

    function automatic int m_sample();
        int up, down, v;
        if (m_mode != M_RUN) return 0;
        case (a_wave)
            1, 4: v = (m_pin() != 0) ? 65535 : 0;
            2:    v = m_cnt;
            3: begin
                // Triangle is the lower of the rising and falling ramps.
                up   = 2 * m_cnt;
                down = 2 * (m_p() - 1 - m_cnt);
                v    = (up < down) ? up : down;
                if (v > 65535) v = 65535;
            end
            default: v = 0;
        endcase
        return v;
    endfunction

    task automatic model_step();
        int  smp, a;
        bit  m_busy, ctrl, start, stop, last_period;
        if (!reset) begin
            foreach (m_reg[i]) m_reg[i] = 0;
            m_mode = M_IDLE; m_arm_left = 0; m_cnt = 0; m_tick = 0;
            m_last = 0; m_rdata = 0; a_wave = 0; a_period = 0; a_duty = 0;
            return;
        end
        a      = int'(cfg_addr);
        smp    = m_sample();
        m_busy = (m_mode == M_ARMED) || (m_mode == M_RUN);
        if (cfg_en && !cfg_wr) begin
            if (a < 5)       m_rdata = m_reg[a];
            else if (a == 5) m_rdata = m_busy ? 1 : 0;
            else if (a == 6) m_rdata = m_tick;
            else             m_rdata = m_last;
        end
        ctrl  = cfg_en && cfg_wr && (a == 5);
        start = ctrl && cfg_wdata[0] && (m_reg[0] >= 1) && (m_reg[0] <= 4);
        stop  = ctrl && !cfg_wdata[0];
        last_period = (m_mode == M_RUN) && (m_cnt == m_p() - 1) && (m_reg[3] != 0)
                      && (((m_tick + 1) % 65536) == m_reg[3]);
        if ((m_mode == M_RUN) && (start || stop || last_period)) m_last = smp;

        if (start) begin
            m_mode     = M_ARMED;
            m_arm_left = (m_reg[2] == 0) ? 1 : m_reg[2];
            m_tick     = 0;
            m_cnt      = 0;
            a_wave = m_reg[0]; a_period = m_reg[1]; a_duty = m_reg[4];
        end else if (stop && m_busy) begin
            m_mode = M_IDLE;
        end else if (m_mode == M_ARMED) begin
            m_arm_left--;
            if (m_arm_left == 0) begin
                m_mode = M_RUN;
                m_cnt  = 0;
            end
        end else if (m_mode == M_RUN) begin
            if (m_cnt == m_p() - 1) begin
                m_cnt  = 0;
                m_tick = (m_tick + 1) % 65536;
                a_wave = m_reg[0]; a_period = m_reg[1]; a_duty = m_reg[4];
                if (last_period) m_mode = M_DONE;
            end else begin
                m_cnt++;
            end
        end else if (m_mode == M_DONE) begin
            m_mode = M_IDLE;
        end

        if (cfg_en && cfg_wr && (a < 5)) m_reg[a] = int'(cfg_wdata);
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        if (chk_en) begin
            check("pin_out", {31'd0, pin_out}, m_pin());
            check("sample", {16'd0, sample}, m_sample());
            check("busy", {31'd0, busy}, ((m_mode == M_ARMED) || (m_mode == M_RUN)) ? 1 : 0);
            check("done", {31'd0, done}, (m_mode == M_DONE) ? 1 : 0);
            check("cfg_rdata", {16'd0, cfg_rdata}, m_rdata);
        end
    end

    // ---------------- stimulus helpers (called at posedge + 1) ----------------
    task automatic drive(input bit en, input bit wr, input int addr, input int data);
        logic [31:0] d;
        d         = data;
        cfg_en    = en;
        cfg_wr    = wr;
        cfg_addr  = addr[2:0];
        cfg_wdata = d[15:0];
        @(posedge clk);
        #1;
        cfg_en    = 1'b0;
        cfg_wr    = 1'b0;
        cfg_addr  = 3'd0;
        cfg_wdata = 16'h0000;
    endtask

    task automatic step();
        drive(1'b0, 1'b0, 0, 0);
    endtask

    task automatic cfg_write(input int addr, input int data);
        drive(1'b1, 1'b1, addr, data);
    endtask

    task automatic cfg_read(input int addr, output logic [15:0] v);
        drive(1'b1, 1'b0, addr, 0);
        v = cfg_rdata;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    task automatic configure(input int w, input int p, input int ph, input int t, input int d);
        cfg_write(0, w);
        cfg_write(1, p);
        cfg_write(2, ph);
        cfg_write(3, t);
        cfg_write(4, d);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [15:0] v;
        logic [15:0] pat16;
        logic [7:0]  pat8, busy8;
        bit          pins[18];
        int          hi, busy_n, done_idx, done_n, r, a, d;
        int          tri_exp[12] = '{0, 2, 4, 4, 2, 0, 0, 2, 4, 4, 2, 0};

        @(posedge clk);
        #1;
        chk_en = 1'b1;
        reset  = 1'b1;

        // Reset state
        check("reset_busy", {31'd0, busy}, 0);
        check("reset_rdata", {16'd0, cfg_rdata}, 0);

        // Square, PERIOD=10, PHASE=0, TICKS=3
        configure(1, 10, 0, 3, 0);
        cfg_write(5, 1);
        hi = 0; busy_n = 0; done_idx = -1;
        for (int i = 0; i < 40; i++) begin
            if (pin_out) hi++;
            if (busy) busy_n++;
            if (done && done_idx < 0) done_idx = i;
            step();
        end
        check("sq_high_cycles", hi, 15);
        check("sq_busy_cycles", busy_n, 31);
        check("sq_done_index", done_idx, 31);
        cfg_read(6, v);
        check("sq_cur_tick", {16'd0, v}, 3);

        // PWM, PERIOD=8, DUTY 3 -> 6 written mid-period
        configure(4, 8, 0, 0, 3);
        cfg_write(5, 1);
        for (int i = 0; i < 18; i++) begin
            pins[i] = pin_out;
            if (i == 2) cfg_write(4, 6);
            else        step();
        end
        for (int j = 0; j < 16; j++) pat16[j] = pins[j + 1];
        check("pwm_duty_switch", {16'd0, pat16}, 32'h3F07);
        cfg_write(5, 0);

        // Triangle, PERIOD=6
        configure(3, 6, 0, 0, 0);
        cfg_write(5, 1);
        step();
        for (int i = 0; i < 12; i++) begin
            check("tri_sample", {16'd0, sample}, tri_exp[i]);
            step();
        end
        cfg_write(5, 0);

        // PHASE=4 with PERIOD=1 (runs as period 2)
        configure(1, 1, 4, 0, 0);
        cfg_write(5, 1);
        for (int i = 0; i < 8; i++) begin
            pat8[i]  = pin_out;
            busy8[i] = busy;
            step();
        end
        check("phase_pin_pattern", {24'd0, pat8}, 32'h50);
        check("phase_busy_pattern", {24'd0, busy8}, 32'hFF);
        cfg_write(5, 0);

        // Sawtooth stopped at cnt=3
        configure(2, 16, 0, 0, 0);
        cfg_write(5, 1);
        done_n = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) done_n++;
            if (i == 4) begin
                check("saw_sample_at_stop", {16'd0, sample}, 3);
                cfg_write(5, 0);
            end else begin
                step();
            end
        end
        check("saw_no_done", done_n, 0);
        check("saw_idle_busy", {31'd0, busy}, 0);
        check("saw_idle_sample", {16'd0, sample}, 0);
        cfg_read(7, v);
        check("saw_last_val", {16'd0, v}, 3);

        // Start with an invalid waveform is ignored
        configure(5, 10, 0, 0, 0);
        cfg_write(5, 1);
        step();
        check("bad_wave_ignored", {31'd0, busy}, 0);

        // Reset mid-run clears everything
        configure(1, 10, 0, 0, 4);
        cfg_write(5, 1);
        repeat (5) step();
        cfg_read(1, v);
        check("pre_reset_busy", {31'd0, busy}, 1);
        do_reset();
        check("rst_pin_out", {31'd0, pin_out}, 0);
        check("rst_sample", {16'd0, sample}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_rdata", {16'd0, cfg_rdata}, 0);
        for (int i = 0; i < 8; i++) begin
            cfg_read(i, v);
            check("rst_reg_read", {16'd0, v}, 0);
        end

        // Randomized register traffic against the model
        for (int n = 0; n < 4000; n++) begin
            r = $urandom_range(0, 199);
            if (r < 100) begin
                step();
            end else if (r < 150) begin
                a = $urandom_range(0, 7);
                case (a)
                    0: d = ((m_mode == M_ARMED) || (m_mode == M_RUN)) ? $urandom_range(1, 4)
                                                                      : $urandom_range(0, 5);
                    1: d = $urandom_range(0, 12);
                    2: d = $urandom_range(0, 5);
                    3: d = $urandom_range(0, 4);
                    4: d = $urandom_range(0, 14);
                    5: d = $urandom_range(0, 65535);
                    default: d = $urandom_range(0, 65535);
                endcase
                cfg_write(a, d);
            end else if (r < 175) begin
                cfg_read($urandom_range(0, 7), v);
            end else if (r < 190) begin
                cfg_write(5, ($urandom_range(0, 32767) << 1) | 1);
            end else if (r < 198) begin
                cfg_write(5, $urandom_range(0, 32767) << 1);
            end else begin
                do_reset();
            end
        end

        repeat (3) step();
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
